// File: rtl/timer_ctrl.sv
// Prescaled up-counting timer with one-shot or periodic reload.
// Configuration is only writable while idle.
module timer_ctrl #(
  parameter int CNT_W = 8,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [PRE_W-1:0] cfg_prescale,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] period;
  logic [PRE_W-1:0] prescale;
  logic             periodic;
  logic [PRE_W-1:0] pre;
  logic             cfg_load;
  logic             term;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign cfg_load  = cfg_valid && cfg_ready;
  assign tick      = busy && (pre == prescale);
  assign term      = tick && (count == period);

  always_ff @(posedge clk) begin
    if (rst) begin
      period   <= '0;
      prescale <= '0;
      periodic <= 1'b0;
    end else if (cfg_load) begin
      period   <= cfg_period;
      prescale <= cfg_prescale;
      periodic <= cfg_periodic;
    end
  end

  // stop outranks any tick or terminal count in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      pre   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= RUN;
            count <= '0;
            pre   <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
          end else begin
            pre <= tick ? '0 : pre + PRE_W'(1);
            if (term) begin
              count <= '0;
              done  <= 1'b1;
              if (!periodic) state <= IDLE;
            end else if (tick) begin
              count <= count + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl.
// Expected observations are queued per cycle, then popped and checked.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_period;
  logic [7:0] cfg_prescale;
  logic       cfg_periodic;
  logic       start;
  logic       stop;
  logic       busy;
  logic       tick;
  logic [7:0] count;
  logic       done;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [11:0] v;
  } exp_t;

  exp_t sb[$];

  timer_ctrl #(.CNT_W(8), .PRE_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_prescale(cfg_prescale),
    .cfg_periodic(cfg_periodic),
    .start       (start),
    .stop        (stop),
    .busy        (busy),
    .tick        (tick),
    .count       (count),
    .done        (done)
  );

  always #5 clk = ~clk;

  // expected fields: busy, tick, count, done, cfg_ready
  task automatic cycle(input string tag, input logic b,
                       input logic t, input logic [7:0] c,
                       input logic d, input logic r);
    exp_t e;
    logic [11:0] obs;
    e.tag = tag;
    e.v   = {b, t, c, d, r};
    sb.push_back(e);
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    obs = {busy, tick, count, done, cfg_ready};
    n_assert++;
    assert (obs === e.v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (busy,tick,count,done,rdy)",
             e.tag, obs, e.v);
    end
  endtask

  task automatic cfg(input logic v, input logic [7:0] per,
                     input logic [7:0] pre, input logic pm);
    cfg_valid    = v;
    cfg_period   = per;
    cfg_prescale = pre;
    cfg_periodic = pm;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    cfg(1'b0, 8'd0, 8'd0, 1'b0);

    cycle("reset", 0, 0, 8'd0, 0, 1);
    rst = 1'b0;
    cycle("post_rst", 0, 0, 8'd0, 0, 1);

    // default config: period 0, prescale 0, one-shot
    start = 1'b1;
    cycle("dflt_run", 1, 1, 8'd0, 0, 0);
    start = 1'b0;
    cycle("dflt_done", 0, 0, 8'd0, 1, 1);
    cycle("dflt_idle", 0, 0, 8'd0, 0, 1);

    // one-shot period 3, config written together with start
    cfg(1'b1, 8'd3, 8'd0, 1'b0);
    start = 1'b1;
    cycle("os_c0", 1, 1, 8'd0, 0, 0);
    cfg(1'b0, 8'd0, 8'd0, 1'b0);
    start = 1'b0;
    for (int c = 1; c <= 3; c++)
      cycle("os_cnt", 1, 1, 8'(c), 0, 0);
    cycle("os_done", 0, 0, 8'd0, 1, 1);
    cycle("os_idle", 0, 0, 8'd0, 0, 1);

    // periodic period 2, prescale 2; start ignored while running
    cfg(1'b1, 8'd2, 8'd2, 1'b1);
    cycle("cfg_p2", 0, 0, 8'd0, 0, 1);
    cfg(1'b0, 8'd0, 8'd0, 1'b0);
    start = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      logic t, d;
      logic [7:0] c;
      t = (k % 3 == 0);
      c = 8'(((k - 1) / 3) % 3);
      d = (k > 1) && ((k - 1) % 3 == 0) && (((k - 1) / 3) % 3 == 0);
      cycle("p2_run", 1, t, c, d, 0);
    end
    start = 1'b0;
    stop  = 1'b1;
    cycle("p2_stop", 0, 0, 8'd0, 0, 1);
    stop  = 1'b0;

    // periodic period 9; stop at count 5 with a rejected write
    cfg(1'b1, 8'd9, 8'd0, 1'b1);
    start = 1'b1;
    cycle("p9_c0", 1, 1, 8'd0, 0, 0);
    cfg(1'b0, 8'd0, 8'd0, 1'b0);
    start = 1'b0;
    for (int c = 1; c <= 5; c++)
      cycle("p9_cnt", 1, 1, 8'(c), 0, 0);
    cfg(1'b1, 8'd7, 8'd0, 1'b0);
    stop = 1'b1;
    cycle("stop5", 0, 0, 8'd5, 0, 1);
    cfg(1'b0, 8'd0, 8'd0, 1'b0);
    stop  = 1'b0;
    start = 1'b1;
    cycle("p9_rerun", 1, 1, 8'd0, 0, 0);
    start = 1'b0;
    for (int c = 1; c <= 9; c++)
      cycle("p9_keep", 1, 1, 8'(c), 0, 0);
    stop = 1'b1;
    cycle("stop_prio", 0, 0, 8'd9, 0, 1);
    stop = 1'b0;

    // rewrite accepted in idle, start+stop stays idle
    cfg(1'b1, 8'd7, 8'd0, 1'b0);
    cycle("cfg7", 0, 0, 8'd9, 0, 1);
    cfg(1'b0, 8'd0, 8'd0, 1'b0);
    start = 1'b1;
    stop  = 1'b1;
    cycle("ss_idle", 0, 0, 8'd9, 0, 1);
    stop = 1'b0;
    cycle("p7_c0", 1, 1, 8'd0, 0, 0);
    start = 1'b0;
    for (int c = 1; c <= 7; c++)
      cycle("p7_cnt", 1, 1, 8'(c), 0, 0);
    cycle("p7_done", 0, 0, 8'd0, 1, 1);

    // period 0, prescale 1, periodic
    cfg(1'b1, 8'd0, 8'd1, 1'b1);
    start = 1'b1;
    cycle("z_c0", 1, 0, 8'd0, 0, 0);
    cfg(1'b0, 8'd0, 8'd0, 1'b0);
    start = 1'b0;
    for (int k = 2; k <= 9; k++)
      cycle("z_run", 1, (k % 2 == 0), 8'd0, (k % 2 == 1), 0);
    stop = 1'b1;
    cycle("z_stop", 0, 0, 8'd0, 0, 1);
    stop = 1'b0;

    // reset mid-run at count 4 clears state and config
    cfg(1'b1, 8'd6, 8'd0, 1'b1);
    start = 1'b1;
    cycle("r_c0", 1, 1, 8'd0, 0, 0);
    cfg(1'b0, 8'd0, 8'd0, 1'b0);
    start = 1'b0;
    for (int c = 1; c <= 4; c++)
      cycle("r_cnt", 1, 1, 8'(c), 0, 0);
    rst = 1'b1;
    cycle("rst_mid", 0, 0, 8'd0, 0, 1);
    rst   = 1'b0;
    start = 1'b1;
    cycle("clr_run", 1, 1, 8'd0, 0, 0);
    start = 1'b0;
    cycle("clr_done", 0, 0, 8'd0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of count and period.
REQ-002 Parameter PRE_W, default 8: width of prescale divisor.
REQ-003 Port clk  input  1: single clock; all logic rising-edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port cfg_valid  input  1: configuration write request.
REQ-006 Port cfg_ready  output  1: configuration accepted this cycle when high with cfg_valid.
REQ-007 Port cfg_period  input  CNT_W: terminal count value.
REQ-008 Port cfg_prescale  input  PRE_W: clock cycles between ticks, minus one.
REQ-009 Port cfg_periodic  input  1: 1 = periodic reload, 0 = one-shot.
REQ-010 Port start  input  1: start request, level sampled per cycle.
REQ-011 Port stop  input  1: stop request, level sampled per cycle.
REQ-012 Port busy  output  1: high while in RUN.
REQ-013 Port tick  output  1: one-cycle count-enable strobe.
REQ-014 Port count  output  CNT_W: current count, registered.
REQ-015 Port done  output  1: one-cycle pulse on terminal count.

Function
REQ-016 The block SHALL implement a two-state FSM: IDLE and RUN.
REQ-017 cfg_ready SHALL equal (state == IDLE); config registers SHALL load on cfg_valid && cfg_ready and hold otherwise.
REQ-018 IDLE -> RUN SHALL occur on the cycle after start is sampled high in IDLE; on that edge count and prescaler SHALL clear to 0.
REQ-019 If cfg_valid and start are high in the same IDLE cycle, the run SHALL use the newly written configuration.
REQ-020 start in RUN SHALL be ignored.
REQ-021 RUN -> IDLE SHALL occur on the cycle after stop is sampled high in RUN; count SHALL hold its last value; no done pulse.
REQ-022 stop SHALL take priority over a tick or terminal count in the same cycle; start and stop together in IDLE SHALL leave the FSM in IDLE.
REQ-023 In RUN the prescaler SHALL increment each cycle and wrap to 0 after reaching the prescale value; tick SHALL be high combinationally for the cycles where the prescaler equals the prescale value; prescale 0 SHALL give tick every RUN cycle.
REQ-024 tick SHALL be 0 in IDLE.
REQ-025 On a tick with count != period, count SHALL become count+1 (modulo 2^CNT_W).
REQ-026 On a tick with count == period, count SHALL become 0 and done SHALL be high (registered) in the following cycle only.
REQ-027 On terminal count in one-shot mode the FSM SHALL go to IDLE; in periodic mode it SHALL stay in RUN.
REQ-028 Period 0 SHALL produce done on every tick, with count remaining 0.
REQ-029 Latency: start high at cycle N with prescale P SHALL give first tick at cycle N+1+P and count == 1 at N+2+P.

Reset
REQ-030 On rst high at a clock edge: state = IDLE, count = 0, prescaler = 0, done = 0, period = 0, prescale = 0, periodic = 0; takes priority over all inputs, including mid-run.
REQ-031 After reset deassertion, cfg_ready SHALL be 1, busy 0, tick 0.

Verification
REQ-032 Config period=3, prescale=0, one-shot, start -> count 1,2,3,0 on consecutive cycles; done pulses once, coincident with count 0; busy falls the same cycle.
REQ-033 period=2, prescale=2, periodic, start at cycle 0 -> tick at cycles 3,6,9,...; done at cycles 10, 19, ...; busy stays 1.
REQ-034 Periodic run with count = 5, assert stop -> busy 0 next cycle, count holds 5, no done; cfg_ready returns 1.
REQ-035 cfg_valid (period=7) during RUN -> cfg_ready 0, period unchanged; after stop, rewrite accepted.
REQ-036 period=0, prescale=1, periodic -> done every second cycle, count always 0.
REQ-037 rst asserted mid-run with count = 4 -> next cycle count 0, busy 0, done 0, config cleared.
